subcarrier_nco: RTL

SUBCARRIER_NCO -- requirements
Module: subcarrier_nco

---
 rtl/subcarrier_nco_if.sv | 20 ++
 rtl/subcarrier_nco.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/subcarrier_nco_if.sv
// Control and sample bundle of the subcarrier NCO: phase steering in, phase plus sin/cos samples out.
interface subcarrier_nco_if;
    logic               enable;
    logic               phase_sync;
    logic signed [31:0] offset_in;
    logic [31:0]        phase_out;
    logic signed [11:0] sin_out;
    logic signed [11:0] cos_out;
    logic               out_valid;

    modport master (
        output enable, phase_sync, offset_in,
        input  phase_out, sin_out, cos_out, out_valid
    );

    modport slave (
        input  enable, phase_sync, offset_in,
        output phase_out, sin_out, cos_out, out_valid
    );
endinterface

// File: rtl/subcarrier_nco.sv
// Subcarrier NCO: clamped-offset phase accumulator feeding a quarter-wave sin/cos lookup, 3-cycle issue-to-sample latency.
// Never stalls; out_valid is the delayed issue flag and outputs hold when idle. NCO_DITHER_EN adds LFSR phase dither.
module subcarrier_nco #(
    parameter logic [31:0] BASE_INC   = 32'd569408543,
    parameter logic [31:0] MAX_OFFSET = 32'd16777216,
    parameter logic [31:0] SYNC_PHASE = 32'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    subcarrier_nco_if.slave nco
);
    logic [31:0]        phase;
    logic signed [31:0] off_c;
    logic [9:0]         addr_top;
    logic [9:0]         sin_addr;
    logic [9:0]         cos_addr;

    always_comb begin
        off_c = nco.offset_in;
        if (nco.offset_in > $signed(MAX_OFFSET))
            off_c = $signed(MAX_OFFSET);
        else if (nco.offset_in < -$signed(MAX_OFFSET))
            off_c = -$signed(MAX_OFFSET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= '0;
        else if (nco.phase_sync)
            phase <= SYNC_PHASE;
        else if (nco.enable)
            phase <= phase + BASE_INC + $unsigned(off_c);
    end

    assign nco.phase_out = phase;

`ifdef NCO_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= 16'hACE1;
        else if (nco.enable)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Dither only perturbs the table address; the reported phase stays exact.
    assign addr_top = 10'((phase + {16'd0, lfsr}) >> 22);
`else
    assign addr_top = phase[31:22];
`endif

    assign sin_addr = addr_top;
    assign cos_addr = addr_top + 10'd256;

    // Quarter-wave table sampled at mid-bin so mirrored quadrants need no +1 correction.
    function automatic logic [10:0] rom_entry(input int i);
        real x;
        real term;
        real s;
        x    = (real'(i) + 0.5) * 3.14159265358979323846 / 512.0;
        term = x;
        s    = x;
        for (int k = 1; k <= 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        return 11'($rtoi(2047.0 * s + 0.5));
    endfunction

    logic [10:0] rom [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        localparam logic [10:0] ENTRY = rom_entry(gi);
        assign rom[gi] = ENTRY;
    end

    logic       s1_vld, s1_sin_neg, s1_cos_neg;
    logic [7:0] s1_sin_idx, s1_cos_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_sin_neg <= 1'b0;
            s1_cos_neg <= 1'b0;
            s1_sin_idx <= '0;
            s1_cos_idx <= '0;
        end else begin
            s1_vld <= nco.enable;
            if (nco.enable) begin
                s1_sin_idx <= sin_addr[8] ? ~sin_addr[7:0] : sin_addr[7:0];
                s1_cos_idx <= cos_addr[8] ? ~cos_addr[7:0] : cos_addr[7:0];
                s1_sin_neg <= sin_addr[9];
                s1_cos_neg <= cos_addr[9];
            end
        end
    end

    logic        s2_vld, s2_sin_neg, s2_cos_neg;
    logic [10:0] s2_sin_mag, s2_cos_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld     <= 1'b0;
            s2_sin_neg <= 1'b0;
            s2_cos_neg <= 1'b0;
            s2_sin_mag <= '0;
            s2_cos_mag <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sin_mag <= rom[s1_sin_idx];
                s2_cos_mag <= rom[s1_cos_idx];
                s2_sin_neg <= s1_sin_neg;
                s2_cos_neg <= s1_cos_neg;
            end
        end
    end

    logic               s3_vld;
    logic signed [11:0] s3_sin, s3_cos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld <= 1'b0;
            s3_sin <= '0;
            s3_cos <= '0;
        end else begin
            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_sin <= s2_sin_neg ? -$signed({1'b0, s2_sin_mag}) : $signed({1'b0, s2_sin_mag});
                s3_cos <= s2_cos_neg ? -$signed({1'b0, s2_cos_mag}) : $signed({1'b0, s2_cos_mag});
            end
        end
    end

    assign nco.sin_out   = s3_sin;
    assign nco.cos_out   = s3_cos;
    assign nco.out_valid = s3_vld;
endmodule
